// File: rtl/btn_conditioner_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } btn_state_t;

  // Bits needed to hold a counter that runs from 0 up to and including term.
  function automatic int cnt_width(input int term);
    return (term < 1) ? 1 : $clog2(term + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces a raw push-button into a clean level plus press/release/auto-repeat pulses.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int DEB_TERM   = STABLE_CYCLES - 1;
  localparam bit REP_EN     = (REPEAT_DELAY != 0);
  localparam int DELAY_TERM = REP_EN ? REPEAT_DELAY - 1 : 0;
  localparam int RATE_TERM  = REPEAT_RATE - 1;
  localparam int DEB_W      = cnt_width(DEB_TERM);
  localparam int REP_W      = cnt_width(max_int(DELAY_TERM, RATE_TERM));

  logic             btn_sync;
  btn_state_t       state;
  logic [DEB_W-1:0] deb_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic             rep_first;
  logic [REP_W-1:0] rep_term;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_sync)
  );

  // First interval after a press uses the initial delay, later ones the repeat rate.
  assign rep_term = rep_first ? REP_W'(DELAY_TERM) : REP_W'(RATE_TERM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      rep_cnt       <= '0;
      rep_first     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_sync) begin
            state   <= ARMING;
            deb_cnt <= '0;
          end
        end
        ARMING: begin
          if (!btn_sync) begin
            state <= IDLE;
          end else if (deb_cnt == DEB_W'(DEB_TERM)) begin
            state       <= PRESSED;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_sync) begin
            state   <= RELEASING;
            deb_cnt <= '0;
          end else if (REP_EN) begin
            // Counter only advances while below terminal, so it can never wrap.
            if (rep_cnt == rep_term) begin
              repeat_pulse <= 1'b1;
              rep_cnt      <= '0;
              rep_first    <= 1'b0;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end
        RELEASING: begin
          if (btn_sync) begin
            state <= PRESSED;
          end else if (deb_cnt == DEB_W'(DEB_TERM)) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with STABLE_CYCLES=4, REPEAT_DELAY=10/0, REPEAT_RATE=3.
module tb_btn_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic btn, btn0;
  logic lvl, prs, rel, rpt;
  logic lvl0, prs0, rel0, rpt0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  btn_conditioner #(.STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)) dut (
    .clk(clk), .reset(reset), .btn_in(btn),
    .btn_level(lvl), .press_pulse(prs), .release_pulse(rel), .repeat_pulse(rpt)
  );

  btn_conditioner #(.STABLE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_RATE(3)) dut0 (
    .clk(clk), .reset(reset), .btn_in(btn0),
    .btn_level(lvl0), .press_pulse(prs0), .release_pulse(rel0), .repeat_pulse(rpt0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    btn   = 1'b0;
    btn0  = 1'b0;
    repeat (3) tick();
    checks++;
    if ({lvl, prs, rel, rpt} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=0000", {lvl, prs, rel, rpt});
    end
    checks++;
    if ({lvl0, prs0, rel0, rpt0} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs0 got=%b exp=0000", {lvl0, prs0, rel0, rpt0});
    end
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({lvl, prs, rel, rpt} !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_idle got=%b exp=0000", {lvl, prs, rel, rpt});
    end
  endtask

  // Press at edge 7, repeats at 17, 20, 23, 26, 29.
  task automatic test_press_repeat;
    logic e_prs, e_lvl, e_rpt;
    btn = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      e_prs = (i == 7);
      e_lvl = (i >= 7);
      e_rpt = (i >= 17) && (((i - 17) % 3) == 0);
      checks++;
      if (prs !== e_prs) begin
        errors++;
        $display("FAIL press_pulse edge=%0d got=%b exp=%b", i, prs, e_prs);
      end
      checks++;
      if (lvl !== e_lvl) begin
        errors++;
        $display("FAIL press_level edge=%0d got=%b exp=%b", i, lvl, e_lvl);
      end
      checks++;
      if (rpt !== e_rpt) begin
        errors++;
        $display("FAIL repeat_pulse edge=%0d got=%b exp=%b", i, rpt, e_rpt);
      end
    end
  endtask

  // Two-cycle low glitch while held: no release, repeat counter pauses 3 edges.
  task automatic test_glitch;
    logic e_rpt;
    for (int j = 1; j <= 11; j++) begin
      btn = (j >= 3);
      tick();
      e_rpt = (j == 2) || (j == 8) || (j == 11);
      checks++;
      if (rpt !== e_rpt) begin
        errors++;
        $display("FAIL glitch_repeat edge=%0d got=%b exp=%b", j, rpt, e_rpt);
      end
      checks++;
      if ({lvl, rel} !== 2'b10) begin
        errors++;
        $display("FAIL glitch_level_rel edge=%0d got=%b exp=10", j, {lvl, rel});
      end
    end
  endtask

  task automatic test_release;
    logic e_rel, e_lvl;
    btn = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e_rel = (k == 7);
      e_lvl = (k < 7);
      checks++;
      if (rel !== e_rel) begin
        errors++;
        $display("FAIL release_pulse edge=%0d got=%b exp=%b", k, rel, e_rel);
      end
      checks++;
      if (lvl !== e_lvl) begin
        errors++;
        $display("FAIL release_level edge=%0d got=%b exp=%b", k, lvl, e_lvl);
      end
      checks++;
      if ({rpt, prs} !== 2'b00) begin
        errors++;
        $display("FAIL release_no_repeat edge=%0d got=%b exp=00", k, {rpt, prs});
      end
    end
  endtask

  // Samples 1,1,1,0,0,1,0 then steady 1 from edge 8: press lands on edge 14.
  task automatic test_bounce;
    logic [6:0] pat;
    logic       e_prs, e_lvl;
    pat = 7'b0100111;
    for (int i = 1; i <= 16; i++) begin
      btn = (i <= 7) ? pat[i-1] : 1'b1;
      tick();
      e_prs = (i == 14);
      e_lvl = (i >= 14);
      checks++;
      if ({prs, lvl, rel, rpt} !== {e_prs, e_lvl, 2'b00}) begin
        errors++;
        $display("FAIL bounce edge=%0d got=%b exp=%b", i, {prs, lvl, rel, rpt}, {e_prs, e_lvl, 2'b00});
      end
    end
    btn = 1'b0;
    repeat (12) tick();
    checks++;
    if (lvl !== 1'b0) begin
      errors++;
      $display("FAIL bounce_cleanup_level got=%b exp=0", lvl);
    end
  endtask

  task automatic test_reset_mid;
    logic e_prs, e_lvl;
    btn = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({lvl, prs, rel, rpt} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_arming got=%b exp=0000", {lvl, prs, rel, rpt});
    end
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      e_prs = (i == 7);
      e_lvl = (i == 7);
      checks++;
      if ({prs, lvl} !== {e_prs, e_lvl}) begin
        errors++;
        $display("FAIL reset_repress edge=%0d got=%b exp=%b", i, {prs, lvl}, {e_prs, e_lvl});
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({lvl, prs} !== 2'b00) begin
      errors++;
      $display("FAIL reset_midpulse got=%b exp=00", {lvl, prs});
    end
    btn = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({lvl, prs, rel, rpt} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_after_release got=%b exp=0000", {lvl, prs, rel, rpt});
    end
  endtask

  task automatic test_no_repeat;
    int n_prs, n_rpt, n_rel, prs_edge;
    n_prs = 0; n_rpt = 0; n_rel = 0; prs_edge = 0;
    btn0 = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (prs0 === 1'b1) begin
        n_prs++;
        prs_edge = i;
      end
      if (rpt0 !== 1'b0) n_rpt++;
    end
    checks++;
    if (n_prs !== 1 || prs_edge !== 7) begin
      errors++;
      $display("FAIL norep_press count=%0d edge=%0d exp count=1 edge=7", n_prs, prs_edge);
    end
    checks++;
    if (n_rpt !== 0) begin
      errors++;
      $display("FAIL norep_repeat count=%0d exp=0", n_rpt);
    end
    checks++;
    if (lvl0 !== 1'b1) begin
      errors++;
      $display("FAIL norep_level_held got=%b exp=1", lvl0);
    end
    btn0 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (rel0 === 1'b1) n_rel++;
      if (rpt0 !== 1'b0) n_rpt++;
    end
    checks++;
    if (n_rel !== 1 || n_rpt !== 0) begin
      errors++;
      $display("FAIL norep_release rel=%0d rpt=%0d exp rel=1 rpt=0", n_rel, n_rpt);
    end
    checks++;
    if (lvl0 !== 1'b0) begin
      errors++;
      $display("FAIL norep_level_released got=%b exp=0", lvl0);
    end
  endtask

  initial begin
    reset = 1'b0;
    btn   = 1'b0;
    btn0  = 1'b0;
    test_reset();
    test_press_repeat();
    test_glitch();
    test_release();
    test_bounce();
    test_reset_mid();
    test_no_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
